// File: rtl/odyssey_video_pkg.sv
// ============================================================================
// Module   : odyssey_video_pkg
// Purpose  : Beam-count widths and default NTSC timing shared by the video path
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package odyssey_video_pkg;

   localparam int HCOUNT_W = 11;
   localparam int VCOUNT_W = 10;

   localparam int NTSC_H_TOTAL  = 910;
   localparam int NTSC_H_ACTIVE = 760;
   localparam int NTSC_HS_START = 780;
   localparam int NTSC_HS_WIDTH = 67;
   localparam int NTSC_V_TOTAL  = 262;
   localparam int NTSC_V_ACTIVE = 240;
   localparam int NTSC_VS_START = 244;
   localparam int NTSC_VS_WIDTH = 3;

   typedef logic [HCOUNT_W-1:0] hcount_t;
   typedef logic [VCOUNT_W-1:0] vcount_t;

endpackage : odyssey_video_pkg

`default_nettype wire

// File: rtl/sync_axis_counter.sv
// ============================================================================
// Module   : sync_axis_counter
// Purpose  : Enabled modulo counter with wrap strobe and blank/sync window flags
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_axis_counter #(
   parameter int W          = 11,
   parameter int TOTAL      = 910,
   parameter int ACTIVE     = 760,
   parameter int SYNC_START = 780,
   parameter int SYNC_WIDTH = 67
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_en,
   output logic [W-1:0] o_count,
   output logic         o_wrap,
   output logic         o_blank,
   output logic         o_sync
);

   // One extra bit so TOTAL or SYNC_START+SYNC_WIDTH equal to 2**W still compare correctly
   localparam int        c_WX         = W + 1;
   localparam logic [W:0] c_LAST       = c_WX'(TOTAL - 1);
   localparam logic [W:0] c_ACTIVE     = c_WX'(ACTIVE);
   localparam logic [W:0] c_SYNC_START = c_WX'(SYNC_START);
   localparam logic [W:0] c_SYNC_END   = c_WX'(SYNC_START + SYNC_WIDTH);

   logic [W-1:0] r_count;
   logic         r_blank;
   logic         r_sync;
   logic         w_last;
   logic [W-1:0] w_next;
   logic [W:0]   w_next_x;

   assign w_last   = ({1'b0, r_count} == c_LAST);
   assign w_next   = w_last ? '0 : r_count + 1'b1;
   assign w_next_x = {1'b0, w_next};

   // Flags decode the next count so they register alongside it
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
         r_blank <= 1'b0;
         r_sync  <= 1'b0;
      end else if (i_en) begin
         r_count <= w_next;
         r_blank <= (w_next_x >= c_ACTIVE);
         r_sync  <= (w_next_x >= c_SYNC_START) && (w_next_x < c_SYNC_END);
      end
   end

   assign o_count = r_count;
   assign o_wrap  = i_en & w_last;
   assign o_blank = r_blank;
   assign o_sync  = r_sync;

endmodule : sync_axis_counter

`default_nettype wire

// File: rtl/odyssey_video_timing.sv
// ============================================================================
// Module   : odyssey_video_timing
// Purpose  : Beam position, sync, blanking and line/frame strobes for video
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module odyssey_video_timing
   import odyssey_video_pkg::*;
#(
   parameter int H_TOTAL  = NTSC_H_TOTAL,
   parameter int H_ACTIVE = NTSC_H_ACTIVE,
   parameter int HS_START = NTSC_HS_START,
   parameter int HS_WIDTH = NTSC_HS_WIDTH,
   parameter int V_TOTAL  = NTSC_V_TOTAL,
   parameter int V_ACTIVE = NTSC_V_ACTIVE,
   parameter int VS_START = NTSC_VS_START,
   parameter int VS_WIDTH = NTSC_VS_WIDTH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ce_pix,
   output logic [HCOUNT_W-1:0] h_count,
   output logic [VCOUNT_W-1:0] v_count,
   output logic                hsync,
   output logic                vsync,
   output logic                hblank,
   output logic                vblank,
   output logic                line_start,
   output logic                frame_start,
   output logic [7:0]          frame_count
);

   if (H_TOTAL > 2048 || V_TOTAL > 1024 ||
       H_ACTIVE > HS_START || HS_START + HS_WIDTH > H_TOTAL ||
       V_ACTIVE > VS_START || VS_START + VS_WIDTH > V_TOTAL) begin : g_bad_timing
      $fatal(1, "odyssey_video_timing: inconsistent timing parameters");
   end

   logic       w_h_wrap;
   logic       w_v_wrap;
   logic       w_v_en;
   logic       r_line_start;
   logic       r_frame_start;
   logic [7:0] r_frame_count;

   sync_axis_counter #(
      .W(HCOUNT_W), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
      .SYNC_START(HS_START), .SYNC_WIDTH(HS_WIDTH)
   ) u_h_axis (
      .clk(clk), .reset(reset), .i_en(ce_pix),
      .o_count(h_count), .o_wrap(w_h_wrap), .o_blank(hblank), .o_sync(hsync)
   );

   assign w_v_en = ce_pix & w_h_wrap;

   sync_axis_counter #(
      .W(VCOUNT_W), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
      .SYNC_START(VS_START), .SYNC_WIDTH(VS_WIDTH)
   ) u_v_axis (
      .clk(clk), .reset(reset), .i_en(w_v_en),
      .o_count(v_count), .o_wrap(w_v_wrap), .o_blank(vblank), .o_sync(vsync)
   );

   // Strobes fall back to 0 on any clk that does not wrap, including ce_pix=0
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= 8'd0;
      end else begin
         r_line_start  <= w_h_wrap;
         r_frame_start <= w_v_wrap;
         if (w_v_wrap) begin
            r_frame_count <= r_frame_count + 8'd1;
         end
      end
   end

   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame_count = r_frame_count;

endmodule : odyssey_video_timing

`default_nettype wire

// File: tb/tb_odyssey_video_timing.sv
// ============================================================================
// Module   : tb_odyssey_video_timing
// Purpose  : Directed checks of NTSC line timing and reduced-size frame timing
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_odyssey_video_timing;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ce_pix = 1'b1;

   logic [10:0] b_h;
   logic [9:0]  b_v;
   logic        b_hs, b_vs, b_hb, b_vb, b_ls, b_fs;
   logic [7:0]  b_fc;

   logic [10:0] s_h;
   logic [9:0]  s_v;
   logic        s_hs, s_vs, s_hb, s_vb, s_ls, s_fs;
   logic [7:0]  s_fc;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Full NTSC timing for line-level checks
   odyssey_video_timing u_dut (
      .clk(clk), .reset(reset), .ce_pix(ce_pix),
      .h_count(b_h), .v_count(b_v), .hsync(b_hs), .vsync(b_vs),
      .hblank(b_hb), .vblank(b_vb), .line_start(b_ls), .frame_start(b_fs),
      .frame_count(b_fc)
   );

   // 20 x 10 raster so whole frames fit in a short run
   odyssey_video_timing #(
      .H_TOTAL(20), .H_ACTIVE(12), .HS_START(14), .HS_WIDTH(3),
      .V_TOTAL(10), .V_ACTIVE(6), .VS_START(7), .VS_WIDTH(2)
   ) u_small (
      .clk(clk), .reset(reset), .ce_pix(ce_pix),
      .h_count(s_h), .v_count(s_v), .hsync(s_hs), .vsync(s_vs),
      .hblank(s_hb), .vblank(s_vb), .line_start(s_ls), .frame_start(s_fs),
      .frame_count(s_fc)
   );

   task automatic chk(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int hs_first, hs_last, hs_cnt, hb_first, hb_cnt;
      int ls_seen, ls_h, ls_v, bad;
      int fs_n, hs_edges, vs_cyc, vs_first, vs_last, vb_cyc, vb_first, fc_at255, fs_bad;
      logic prev_hs;

      // Reset held with ce_pix active
      reset = 1'b0;
      ce_pix = 1'b1;
      repeat (5) step();
      chk("rst_h", b_h, 0);
      chk("rst_v", b_v, 0);
      chk("rst_flags", {b_hs, b_vs, b_hb, b_vb, b_ls, b_fs}, 0);
      chk("rst_fc", b_fc, 0);
      chk("rst_small_hv", {s_h, s_v}, 0);

      reset = 1'b1;
      step();
      chk("first_ce_h", b_h, 1);
      chk("first_ce_ls", b_ls, 0);
      chk("first_ce_small_h", s_h, 1);

      // Walk one full NTSC line
      hs_first = -1; hs_last = -1; hs_cnt = 0;
      hb_first = -1; hb_cnt = 0;
      ls_seen = 0; ls_h = -1; ls_v = -1;
      for (int i = 0; i < 1000 && ls_seen == 0; i++) begin
         step();
         if (b_hs) begin
            if (hs_first < 0) hs_first = b_h;
            hs_last = b_h;
            hs_cnt++;
         end
         if (b_hb) begin
            if (hb_first < 0) hb_first = b_h;
            hb_cnt++;
         end
         if (b_ls) begin
            ls_seen = 1; ls_h = b_h; ls_v = b_v;
         end
      end
      chk("line_start_seen", ls_seen, 1);
      chk("wrap_h", ls_h, 0);
      chk("wrap_v", ls_v, 1);
      chk("hsync_first", hs_first, 780);
      chk("hsync_last", hs_last, 846);
      chk("hsync_len", hs_cnt, 67);
      chk("hblank_first", hb_first, 760);
      chk("hblank_len", hb_cnt, 150);
      step();
      chk("ls_one_clk", b_ls, 0);
      chk("after_wrap_h", b_h, 1);

      // Freeze at end of line with ce_pix low
      repeat (908) step();
      chk("pre_hold_h", b_h, 909);
      ce_pix = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (b_h != 909 || b_v != 1 || b_ls || !b_hb) bad++;
      end
      chk("ce_hold_bad", bad, 0);
      ce_pix = 1'b1;
      step();
      chk("ce_resume_h", b_h, 0);
      chk("ce_resume_v", b_v, 2);
      chk("ce_resume_ls", b_ls, 1);

      // Frame-level behaviour on the reduced raster, 256 frames
      reset = 1'b0;
      step();
      reset = 1'b1;
      fs_n = 0; hs_edges = 0; prev_hs = 1'b0;
      vs_cyc = 0; vs_first = -1; vs_last = -1;
      vb_cyc = 0; vb_first = -1; fc_at255 = -1; fs_bad = 0;
      for (int i = 0; i < 51200; i++) begin
         step();
         if (fs_n == 0) begin
            if (s_hs && !prev_hs) hs_edges++;
            if (s_vs) begin
               if (vs_first < 0) vs_first = s_v;
               vs_last = s_v;
               vs_cyc++;
            end
            if (s_vb) begin
               if (vb_first < 0) vb_first = s_v;
               vb_cyc++;
            end
         end
         prev_hs = s_hs;
         if (s_fs) begin
            fs_n++;
            if (s_h != 0 || s_v != 0 || int'(s_fc) != fs_n % 256) fs_bad++;
            if (fs_n == 255) fc_at255 = s_fc;
         end
      end
      chk("hsync_per_frame", hs_edges, 10);
      chk("vsync_first", vs_first, 7);
      chk("vsync_last", vs_last, 8);
      chk("vsync_cycles", vs_cyc, 40);
      chk("vblank_first", vb_first, 6);
      chk("vblank_cycles", vb_cyc, 80);
      chk("frame_starts", fs_n, 256);
      chk("frame_start_bad", fs_bad, 0);
      chk("fc_at_255", fc_at255, 255);
      chk("fc_wrapped", s_fc, 0);

      // Mid-frame reset
      repeat (308) step();
      chk("mid_pre_hv", {21'(s_h), 11'(s_v)}, {21'd8, 11'd5});
      chk("mid_pre_fc", s_fc, 1);
      reset = 1'b0;
      step();
      chk("mid_rst_small", {s_h, s_v, s_fc}, 0);
      chk("mid_rst_flags", {s_hs, s_vs, s_hb, s_vb, s_ls, s_fs}, 0);
      chk("mid_rst_big", {b_h, b_v, b_ls, b_fs}, 0);
      reset = 1'b1;
      step();
      chk("mid_rel_h", s_h, 1);
      chk("mid_rel_strobes", {s_ls, s_fs, b_ls, b_fs}, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_odyssey_video_timing

`default_nettype wire
